// File: rtl/usb_avalon_pkg.sv
// Shared types and defaults for the USB wrapper command master: FSM state
// encoding and the 17-bit command record held in the command FIFO.
package usb_avalon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  localparam int CMD_W                   = 17;
  localparam int DEF_CMD_FIFO_DEPTH      = 4;
  localparam int DEF_CMD_FIFO_ADDR_WIDTH = 2;
  localparam int DEF_TIMEOUT_CYCLES      = 255;

endpackage

// File: rtl/usb_cmd_fifo.sv
// Single-clock command FIFO with show-ahead head output; occupancy is
// derived from read/write pointers carrying one extra wrap bit.
module usb_cmd_fifo #(
  parameter int WIDTH      = 17,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr_reg;
  logic [ADDR_WIDTH:0] rd_ptr_reg;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]) &&
                 (wr_ptr_reg[ADDR_WIDTH-1:0] == rd_ptr_reg[ADDR_WIDTH-1:0]);
  assign head  = mem[rd_ptr_reg[ADDR_WIDTH-1:0]];

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/usb_avalon_cmd_master.sv
// Avalon-MM master driving the USB wrapper register port: queued commands,
// one transfer per command with waitrequest timeout, in-order responses.
module usb_avalon_cmd_master
  import usb_avalon_pkg::*;
#(
  parameter int CMD_FIFO_DEPTH      = DEF_CMD_FIFO_DEPTH,
  parameter int CMD_FIFO_ADDR_WIDTH = DEF_CMD_FIFO_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES      = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [7:0] avm_address,
  output logic [7:0] avm_writedata,
  input  logic [7:0] avm_readdata,
  output logic       avm_write,
  output logic       avm_read,
  output logic       avm_chipselect,
  input  logic       avm_waitrequest,
  input  logic       irq_in,
  output logic       irq_event
);

  localparam int TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW:0] TIMEOUT_VAL = (TW+1)'(TIMEOUT_CYCLES);
  localparam logic [TW:0] CNT_ONE     = (TW+1)'(1);

  state_t        state_reg, state_next;
  logic [7:0]    addr_reg, addr_next;
  logic [7:0]    wdata_reg, wdata_next;
  logic          cs_reg, cs_next;
  logic          read_reg, read_next;
  logic          write_reg, write_next;
  logic          rsp_valid_reg, rsp_valid_next;
  logic [7:0]    rsp_rdata_reg, rsp_rdata_next;
  logic          rsp_err_reg, rsp_err_next;
  logic [TW-1:0] wait_cnt_reg, wait_cnt_next;
  logic [TW:0]   wait_cnt_inc;
  logic          timeout_hit;
  logic          irq_d_reg;
  logic          irq_event_reg;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          launch;
  cmd_t          push_cmd;
  cmd_t          head_cmd;

  assign cmd_ready = !reset && !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign push_cmd  = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

  usb_cmd_fifo #(
    .WIDTH      (CMD_W),
    .DEPTH      (CMD_FIFO_DEPTH),
    .ADDR_WIDTH (CMD_FIFO_ADDR_WIDTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .srst      (reset),
    .push      (fifo_push),
    .push_data (push_cmd),
    .pop       (launch),
    .head      (head_cmd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The extra top bit flags overflow so the counter can saturate.
  assign wait_cnt_inc = {1'b0, wait_cnt_reg} + CNT_ONE;
  assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (wait_cnt_inc >= TIMEOUT_VAL);

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    cs_next        = cs_reg;
    read_next      = read_reg;
    write_next     = write_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_err_next   = rsp_err_reg;
    wait_cnt_next  = wait_cnt_reg;
    launch         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          launch = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (!avm_waitrequest) begin
          cs_next        = 1'b0;
          read_next      = 1'b0;
          write_next     = 1'b0;
          rsp_rdata_next = read_reg ? avm_readdata : 8'h00;
          rsp_err_next   = 1'b0;
          rsp_valid_next = 1'b1;
          state_next     = ST_RESP;
        end else begin
          wait_cnt_next = wait_cnt_inc[TW] ? wait_cnt_reg : wait_cnt_inc[TW-1:0];
          if (timeout_hit) begin
            cs_next        = 1'b0;
            read_next      = 1'b0;
            write_next     = 1'b0;
            rsp_rdata_next = 8'h00;
            rsp_err_next   = 1'b1;
            rsp_valid_next = 1'b1;
            state_next     = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          if (!fifo_empty) begin
            launch = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Pop the head straight into the strobe/address registers.
    if (launch) begin
      addr_next     = head_cmd.addr;
      wdata_next    = head_cmd.wdata;
      cs_next       = 1'b1;
      read_next     = !head_cmd.write;
      write_next    = head_cmd.write;
      wait_cnt_next = '0;
      state_next    = ST_ACCESS;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      cs_reg        <= 1'b0;
      read_reg      <= 1'b0;
      write_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      wait_cnt_reg  <= '0;
      irq_d_reg     <= 1'b0;
      irq_event_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      cs_reg        <= cs_next;
      read_reg      <= read_next;
      write_reg     <= write_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
      wait_cnt_reg  <= wait_cnt_next;
      irq_d_reg     <= irq_in;
      irq_event_reg <= irq_in && !irq_d_reg;
    end
  end

  assign avm_address    = addr_reg;
  assign avm_writedata  = wdata_reg;
  assign avm_chipselect = cs_reg;
  assign avm_read       = read_reg;
  assign avm_write      = write_reg;
  assign rsp_valid      = rsp_valid_reg;
  assign rsp_rdata      = rsp_rdata_reg;
  assign rsp_err        = rsp_err_reg;
  assign irq_event      = irq_event_reg;

endmodule

// File: tb/tb_usb_avalon_cmd_master.sv
// Bench for usb_avalon_cmd_master: transaction-level model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_usb_avalon_cmd_master;

  localparam int DEPTH = 4;
  localparam int TO    = 8;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0, cmd_wdata = '0;
  logic       cmd_ready;
  logic       rsp_valid, rsp_err;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_rdata;
  logic [7:0] avm_address, avm_writedata, avm_readdata;
  logic       avm_write, avm_read, avm_chipselect, avm_waitrequest;
  logic       irq_in = 1'b0, irq_event;

  // Slave: waitrequest held for ws_cfg cycles of each access.
  int         ws_cfg = 0;
  bit         slv_mode = 1'b0;
  logic [7:0] slv_rdata = '0;
  int         slv_cnt = 0;
  assign avm_waitrequest = avm_chipselect && (slv_cnt < ws_cfg);
  assign avm_readdata    = slv_mode ? avm_address + 8'h40 : slv_rdata;
  always @(posedge clk) slv_cnt <= (avm_chipselect && avm_waitrequest) ? slv_cnt + 1 : 0;

  usb_avalon_cmd_master #(
    .CMD_FIFO_DEPTH(DEPTH), .CMD_FIFO_ADDR_WIDTH(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .avm_address(avm_address), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_write(avm_write), .avm_read(avm_read), .avm_chipselect(avm_chipselect),
    .avm_waitrequest(avm_waitrequest), .irq_in(irq_in), .irq_event(irq_event)
  );

  int n_vec = 0, n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: pending command queue, one transfer in flight, one held response.
  logic [16:0] m_q[$];
  logic [16:0] m_cur = '0;
  bit          m_busy = 0, m_hold = 0, m_ev = 0, m_prev = 0, m_err = 0, m_acc = 0;
  int          m_waits = 0;
  logic [7:0]  m_rdata = '0;

  task automatic m_start();
    m_cur   = m_q.pop_front();
    m_busy  = 1;
    m_waits = 0;
  endtask

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_q.delete();
      m_busy = 0; m_hold = 0; m_ev = 0; m_prev = 0;
    end else begin
      m_acc  = cmd_valid && (m_q.size() < DEPTH);
      m_ev   = irq_in && !m_prev;
      m_prev = irq_in;
      if (m_busy) begin
        if (m_waits >= ws_cfg) begin
          m_rdata = m_cur[16] ? 8'h00 : (slv_mode ? m_cur[15:8] + 8'h40 : slv_rdata);
          m_err = 0; m_busy = 0; m_hold = 1;
        end else begin
          m_waits++;
          if (TO != 0 && m_waits == TO) begin
            m_rdata = 8'h00; m_err = 1; m_busy = 0; m_hold = 1;
          end
        end
      end else if (m_hold) begin
        if (rsp_ready) begin
          m_hold = 0;
          if (m_q.size() > 0) m_start();
        end
      end else if (m_q.size() > 0) begin
        m_start();
      end
      if (m_acc) m_q.push_back({cmd_write, cmd_addr, cmd_wdata});
    end
  end

  // Per-cycle compare against the model, plus observation counters.
  int          stb_cyc = 0, irq_cyc = 0, irq_rise = 0;
  bit          irq_last = 0;
  logic [8:0]  rsp_log[$];

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("cmd_ready", cmd_ready, !reset && (m_q.size() < DEPTH));
      chk("avm_chipselect", avm_chipselect, m_busy);
      chk("avm_read", avm_read, m_busy && !m_cur[16]);
      chk("avm_write", avm_write, m_busy && m_cur[16]);
      if (m_busy) chk("avm_address", avm_address, m_cur[15:8]);
      if (m_busy && m_cur[16]) chk("avm_writedata", avm_writedata, m_cur[7:0]);
      chk("rsp_valid", rsp_valid, m_hold);
      if (m_hold) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", rsp_err, m_err);
      end
      chk("irq_event", irq_event, m_ev);
      if (avm_chipselect) stb_cyc++;
      if (irq_event) begin
        irq_cyc++;
        if (!irq_last) irq_rise++;
      end
      irq_last = irq_event;
      if (rsp_valid && rsp_ready) begin
        rsp_log.push_back({rsp_err, rsp_rdata});
        $display("[%0t] response %0d: rdata=0x%02h err=%0b", $time, rsp_log.size(), rsp_rdata, rsp_err);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input bit w, input logic [7:0] a, input logic [7:0] d);
    bit done = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 64 && !done; i++) begin
      done = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    $display("[%0t] command w=%0b addr=0x%02h wdata=0x%02h accepted=%0b", $time, w, a, d, done);
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL push_timeout: got accepted=0, expected accepted=1 (addr 0x%02h)", a);
    end
  endtask

  task automatic wait_rsp(input int n);
    int k = 0;
    while (rsp_log.size() < n && k < 200) begin @(posedge clk); #1; k++; end
    if (rsp_log.size() < n) begin
      n_vec++; n_bad++;
      $display("FAIL rsp_timeout: got %0d responses, expected %0d", rsp_log.size(), n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  int base, s0, i0, c0;
  logic [8:0] bp_exp [5];

  initial begin
    @(posedge clk); #1;
    chk_en = 1;
    cyc(2);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_strobes", {avm_chipselect, avm_read, avm_write}, 0);
    chk("rst_avm_address", avm_address, 0);
    chk("rst_avm_writedata", avm_writedata, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("rst_irq_event", irq_event, 0);
    reset = 0;
    cyc(1);
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // Zero-wait write, exact latency.
    ws_cfg = 0; rsp_ready = 1;
    push(1, 8'h10, 8'hA5);
    chk("w0_no_strobe_yet", avm_chipselect, 0);
    cyc(1);
    chk("w0_strobe", {avm_chipselect, avm_write, avm_read}, 3'b110);
    chk("w0_addr", avm_address, 8'h10);
    chk("w0_wdata", avm_writedata, 8'hA5);
    cyc(1);
    chk("w0_strobe_drop", avm_chipselect, 0);
    chk("w0_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 8'h00});
    cyc(2);

    // Read with three waitstates.
    base = rsp_log.size(); s0 = stb_cyc;
    ws_cfg = 3; slv_rdata = 8'h5C;
    push(0, 8'h03, 8'h00);
    wait_rsp(base + 1);
    chk("r3_strobe_cycles", stb_cyc - s0, 4);
    chk("r3_rsp", rsp_log[base], 9'h05C);

    // Timeout, then the queued write completes normally.
    base = rsp_log.size(); s0 = stb_cyc;
    ws_cfg = 1000;
    push(0, 8'h20, 8'h00);
    push(1, 8'h21, 8'h77);
    wait_rsp(base + 1);
    chk("to_strobe_cycles", stb_cyc - s0, TO);
    chk("to_rsp", rsp_log[base], 9'h100);
    ws_cfg = 0;
    wait_rsp(base + 2);
    chk("to_next_rsp", rsp_log[base + 1], 9'h000);

    // Backpressure: five commands with responses stalled.
    rsp_ready = 0; ws_cfg = 0; slv_mode = 1;
    base = rsp_log.size(); s0 = stb_cyc;
    push(0, 8'h30, 8'h00);
    push(1, 8'h31, 8'h11);
    push(0, 8'h32, 8'h00);
    push(0, 8'h33, 8'h00);
    push(1, 8'h34, 8'h44);
    chk("bp_cmd_ready_full", cmd_ready, 0);
    chk("bp_one_transfer", stb_cyc - s0, 1);
    rsp_ready = 1;
    wait_rsp(base + 5);
    bp_exp[0] = 9'h070; bp_exp[1] = 9'h000; bp_exp[2] = 9'h072;
    bp_exp[3] = 9'h073; bp_exp[4] = 9'h000;
    for (int i = 0; i < 5; i++) chk($sformatf("bp_rsp%0d", i), rsp_log[base + i], bp_exp[i]);
    chk("bp_transfers", stb_cyc - s0, 5);
    slv_mode = 0;

    // Reset during a stalled access flushes everything.
    ws_cfg = 1000;
    push(0, 8'h50, 8'h00);
    push(1, 8'h51, 8'h99);
    push(0, 8'h52, 8'h00);
    cyc(2);
    chk("ra_in_access", avm_read, 1);
    reset = 1;
    cyc(1);
    chk("ra_strobes", {avm_chipselect, avm_read, avm_write}, 0);
    chk("ra_rsp_valid", rsp_valid, 0);
    chk("ra_cmd_ready", cmd_ready, 0);
    reset = 0;
    base = rsp_log.size(); s0 = stb_cyc; ws_cfg = 0;
    cyc(1);
    chk("ra_fifo_empty", cmd_ready, 1);
    cyc(20);
    chk("ra_no_rsp", rsp_log.size(), base);
    chk("ra_no_replay", stb_cyc - s0, 0);

    // irq rising edges.
    i0 = irq_rise; c0 = irq_cyc;
    irq_in = 1; cyc(10);
    irq_in = 0; cyc(3);
    irq_in = 1; cyc(3);
    irq_in = 0; cyc(3);
    chk("irq_pulses", irq_rise - i0, 2);
    chk("irq_pulse_cycles", irq_cyc - c0, 2);
    i0 = irq_rise; c0 = irq_cyc;
    irq_in = 1; reset = 1; cyc(3);
    reset = 0; cyc(4);
    irq_in = 0; cyc(2);
    chk("irq_after_reset_pulses", irq_rise - i0, 1);
    chk("irq_after_reset_cycles", irq_cyc - c0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
